adc_scan_apb_master: RTL and testbench
======================================

Name: adc_scan_apb_master

Overview:
- APB requester that autonomously scans ADC channels by driving the ADC's APB completer.
- Per enabled channel, in ascending channel order: select AMUX, assert trigger, poll status until ready, read measurement, clear trigger, hand the result out on a valid/ready stream.
- Sits between a control/CPU-side register block or DMA and the ADC wrapper's APB port. Replaces software polling.

Parameters:
ADDR_WIDTH, 12, APB address width
DATA_WIDTH, 32, APB data width
CH_W, 3, channel index width; NUM_CH = 2**CH_W
POLL_LIMIT, 255, max STATUS reads per channel before timeout (>=1)
STATUS_ADDR, 12'h001, status register offset; bit0 = conversion ready
MEAS_ADDR, 12'h002, measurement register offset
AMUX_ADDR, 12'h101, analog mux select offset
TRIG_ADDR, 12'h102, trigger register offset

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESETn  in  1  reset, synchronous, active-low
start  in  1  single-cycle scan request
ch_mask  in  NUM_CH  enabled channels, sampled on accepted start
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan end (normal or abort)
err_code  out  2  00 none, 01 PSLVERR, 10 poll timeout; sticky until next accepted start
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_ch  out  CH_W  channel of result
result_data  out  DATA_WIDTH  measurement word
PSEL  out  1  APB select
PENABLE  out  1  APB access phase
PWRITE  out  1  1 = write
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  completer ready
PSLVERR  in  1  completer error, valid with PREADY

Behaviour:
- Reset (PRESETn low at a PCLK edge): state IDLE. All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy, done, err_code, result_valid, result_ch, result_data. Takes effect at the next edge even mid-transfer.
- APB transfer rules:
  - SETUP: one cycle, PSEL=1, PENABLE=0.
  - ACCESS: PENABLE=1, held until PREADY=1.
  - PADDR, PWRITE and PWDATA are stable from SETUP through completion.
  - After completion, either the next SETUP or PSEL=0. Back-to-back transfers are allowed.
  - Unused PWDATA is 0 on reads.
- FSM: IDLE -> FIND -> WR_AMUX -> WR_TRIG -> POLL -> RD_MEAS -> CLR_TRIG -> OUT -> FIND ... -> FINISH -> IDLE.
- IDLE: start=1 -> latch ch_mask, clear err_code, busy=1, go to FIND. start while busy is ignored.
- FIND: one cycle. Select the lowest set bit of the pending mask as the current channel and clear that bit. If no bit is set -> FINISH.
- WR_AMUX: write AMUX_ADDR with PWDATA = zero-extended channel.
- WR_TRIG: write TRIG_ADDR with PWDATA = 1.
- POLL: read STATUS_ADDR.
  - PRDATA[0]=1 at completion -> RD_MEAS.
  - Otherwise increment the poll counter and issue another read.
  - Counter reaching POLL_LIMIT without ready -> err_code=10, abort.
  - The counter clears on entry to POLL.
- RD_MEAS: read MEAS_ADDR. Capture PRDATA into result_data and the channel into result_ch.
- CLR_TRIG: write TRIG_ADDR with 0.
- OUT: result_valid=1 and held with data stable until result_ready=1. On the handshake cycle: result_valid=0, go to FIND. No APB activity in OUT.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- PSLVERR=1 at any completion (PREADY=1):
  - err_code=01, abort.
  - Abort means PSEL/PENABLE=0 next cycle, remaining channels discarded, no trigger clear, FINISH.
  - No result is emitted for the failing channel.
- ch_mask=0 on start: no APB traffic; done pulses 2 cycles after start (FIND then FINISH).
- Zero-wait-state latency: ready on first poll gives 10 cycles from FIND exit to result_valid. Each PREADY wait cycle adds 1 cycle.
- done and the final result handshake never coincide. done follows the last OUT by 2 cycles (FIND, FINISH).

Test Plan:
1. Single channel, no waits: start with ch_mask=8'h04, status ready on first read, PRDATA=32'h0000_0ABC at MEAS. Expect exact APB sequence W 0x101=2, W 0x102=1, R 0x001, R 0x002, W 0x102=0; result_valid with result_ch=2, result_data=0xABC; done 2 cycles after result_ready.
2. Multi-channel with backpressure: ch_mask=8'h81, result_ready low for 5 cycles each time. Expect results for ch 0 then ch 7; result_valid and data held stable while stalled; no APB activity while in OUT.
3. Wait states and polling: PREADY low 3 cycles per access, status ready on the 4th read. Expect exactly 4 STATUS reads, address/data stable through waits, correct result.
4. Timeout: POLL_LIMIT=4, status never ready. Expect 4 STATUS reads, err_code=10, done pulse, no result, no trigger-clear write, busy=0.
5. PSLVERR on WR_TRIG for ch 1 of mask 8'h03. Expect err_code=01, ch 0 result delivered, no further APB transfers, done pulse; next start clears err_code.
6. Reset and edge cases:
   - PRESETn low during the ACCESS phase of POLL -> all outputs 0 next edge.
   - ch_mask=0 -> done pulse 2 cycles after start, PSEL never asserted.
   - start asserted while busy -> ignored.

Source files
------------

// File: rtl/adc_scan_apb_master.sv
// Scans the enabled ADC channels in ascending order over APB; 10 cycles from FIND exit to result_valid at zero wait states.
// Backpressure: a result is held in OUT until result_ready, with the APB bus idle; PREADY stretches each access.
module adc_scan_apb_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int CH_W = 3,
  parameter int POLL_LIMIT = 255,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 'h001,
  parameter logic [ADDR_WIDTH-1:0] MEAS_ADDR = 'h002,
  parameter logic [ADDR_WIDTH-1:0] AMUX_ADDR = 'h101,
  parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR = 'h102
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    start,
  input  logic [(2**CH_W)-1:0]    ch_mask,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err_code,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [CH_W-1:0]         result_ch,
  output logic [DATA_WIDTH-1:0]   result_data,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int NUM_CH = 2**CH_W;
  localparam int PCW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FIND, S_WR_AMUX, S_WR_TRIG, S_POLL,
    S_RD_MEAS, S_CLR_TRIG, S_OUT, S_FINISH
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] pend_mask;
  logic [CH_W-1:0]   cur_ch;
  logic [PCW-1:0]    poll_cnt;
  logic [CH_W-1:0]   low_ch;

  // Lowest pending channel; scanning downward leaves the smallest index last.
  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_mask[i]) low_ch = CH_W'(i);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state        <= S_IDLE;
      pend_mask    <= '0;
      cur_ch       <= '0;
      poll_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_code     <= 2'b00;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pend_mask <= ch_mask;
            err_code  <= 2'b00;
            busy      <= 1'b1;
            state     <= S_FIND;
          end
        end

        S_FIND: begin
          if (|pend_mask) begin
            cur_ch            <= low_ch;
            pend_mask[low_ch] <= 1'b0;
            PSEL              <= 1'b1;
            PENABLE           <= 1'b0;
            PWRITE            <= 1'b1;
            PADDR             <= AMUX_ADDR;
            PWDATA            <= DATA_WIDTH'(low_ch);
            state             <= S_WR_AMUX;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FINISH;
          end
        end

        S_WR_AMUX, S_WR_TRIG, S_POLL, S_RD_MEAS, S_CLR_TRIG: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            if (PSLVERR) begin
              // Abort: trigger is left set and remaining channels are dropped.
              err_code <= 2'b01;
              PSEL     <= 1'b0;
              PENABLE  <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_FINISH;
            end else begin
              PENABLE <= 1'b0;
              case (state)
                S_WR_AMUX: begin
                  PADDR  <= TRIG_ADDR;
                  PWDATA <= DATA_WIDTH'(1);
                  state  <= S_WR_TRIG;
                end
                S_WR_TRIG: begin
                  PWRITE   <= 1'b0;
                  PADDR    <= STATUS_ADDR;
                  PWDATA   <= '0;
                  poll_cnt <= '0;
                  state    <= S_POLL;
                end
                S_POLL: begin
                  if (PRDATA[0]) begin
                    PADDR <= MEAS_ADDR;
                    state <= S_RD_MEAS;
                  end else if (int'(poll_cnt) + 1 >= POLL_LIMIT) begin
                    err_code <= 2'b10;
                    PSEL     <= 1'b0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_FINISH;
                  end else begin
                    // PSEL stays high: the next cycle is a fresh SETUP of the same read.
                    poll_cnt <= poll_cnt + PCW'(1);
                  end
                end
                S_RD_MEAS: begin
                  result_data <= PRDATA;
                  result_ch   <= cur_ch;
                  PWRITE      <= 1'b1;
                  PADDR       <= TRIG_ADDR;
                  PWDATA      <= '0;
                  state       <= S_CLR_TRIG;
                end
                default: begin
                  PSEL         <= 1'b0;
                  PWRITE       <= 1'b0;
                  PADDR        <= '0;
                  result_valid <= 1'b1;
                  state        <= S_OUT;
                end
              endcase
            end
          end
        end

        S_OUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= S_FIND;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_apb_master.sv
// Directed and randomized scans against a transaction-level model of the expected APB traffic and results.
module tb_adc_scan_apb_master;

  localparam int PL = 4;
  localparam logic [11:0] A_STATUS = 12'h001;
  localparam logic [11:0] A_MEAS   = 12'h002;
  localparam logic [11:0] A_AMUX   = 12'h101;
  localparam logic [11:0] A_TRIG   = 12'h102;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        result_ready = 1'b0;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        busy, done, result_valid, PSEL, PENABLE, PWRITE;
  logic [1:0]  err_code;
  logic [2:0]  result_ch;
  logic [31:0] result_data, PWDATA;
  logic [11:0] PADDR;

  always #5 PCLK = ~PCLK;

  adc_scan_apb_master #(.POLL_LIMIT(PL)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .ch_mask(ch_mask),
    .busy(busy), .done(done), .err_code(err_code),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_ch(result_ch), .result_data(result_data),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct packed {logic wr; logic [11:0] addr; logic [31:0] data;} xfer_t;
  typedef struct packed {logic [2:0] ch; logic [31:0] data;} res_t;

  xfer_t obs_q[$];
  xfer_t exp_q[$];
  res_t  got_q[$];
  res_t  exp_res[$];

  int checks = 0;
  int errors = 0;

  // Completer configuration
  int          cfg_waits = 0;
  bit          cfg_rand_waits = 0;
  int          cfg_status_at = 1;
  bit          cfg_err_en = 0;
  int          cfg_err_ch = 0;
  int          cfg_err_step = 0;
  logic [31:0] meas [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input xfer_t x);
    if (x.wr && x.addr == A_AMUX) return 0;
    if (x.wr && x.addr == A_TRIG && x.data == 32'd1) return 1;
    if (!x.wr && x.addr == A_STATUS) return 2;
    if (!x.wr && x.addr == A_MEAS) return 3;
    if (x.wr && x.addr == A_TRIG && x.data == 32'd0) return 4;
    return 9;
  endfunction

  // APB completer: wait states, status/measurement data and error injection
  int    wait_left = 0;
  int    stat_cnt = 0;
  int    cur_ch = 0;
  bit    in_xfer = 0;
  xfer_t setup_x;
  initial begin
    logic [31:0] r;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        PREADY = 0; PSLVERR = 0; PRDATA = 0; wait_left = 0; in_xfer = 0; stat_cnt = 0;
      end else if (PSEL && !PENABLE) begin
        setup_x.wr = PWRITE; setup_x.addr = PADDR; setup_x.data = PWDATA;
        wait_left = cfg_rand_waits ? int'($urandom_range(0, 2)) : cfg_waits;
        in_xfer = 1;
        if (PWRITE && PADDR == A_AMUX) begin
          cur_ch = int'(PWDATA[2:0]);
          stat_cnt = 0;
        end
        if (!PWRITE) check("rd_pwdata_zero", PWDATA, 32'h0);
        PREADY = 0; PSLVERR = 0;
      end else if (PSEL && PENABLE) begin
        check("access_after_setup", 32'(in_xfer), 32'd1);
        check("apb_stable_ctl", {19'h0, PWRITE, PADDR}, {19'h0, setup_x.wr, setup_x.addr});
        check("apb_stable_wdata", PWDATA, setup_x.data);
        if (wait_left > 0) begin
          PREADY = 0; PSLVERR = 0; PRDATA = $urandom; wait_left--;
        end else begin
          PREADY = 1;
          PSLVERR = cfg_err_en && cur_ch == cfg_err_ch && step_of(setup_x) == cfg_err_step;
          r = $urandom;
          if (step_of(setup_x) == 2) begin
            stat_cnt++;
            r[0] = (cfg_status_at != 0 && stat_cnt == cfg_status_at);
          end else if (step_of(setup_x) == 3) begin
            r = meas[cur_ch];
          end
          PRDATA = r;
          obs_q.push_back(setup_x);
          in_xfer = 0;
        end
      end else begin
        PREADY = 0; PSLVERR = 0; in_xfer = 0;
      end
    end
  end

  // Reference model: the transfer list and results one scan should produce
  function automatic bit push_step(input int ch, input int stp, input bit wr,
                                   input logic [11:0] a, input logic [31:0] d);
    xfer_t x;
    x.wr = wr; x.addr = a; x.data = d;
    exp_q.push_back(x);
    return cfg_err_en && ch == cfg_err_ch && stp == cfg_err_step;
  endfunction

  task automatic build_expect(input logic [7:0] mask, output logic [1:0] e_err);
    int   npoll;
    bit   ready_ok;
    res_t rr;
    exp_q.delete(); exp_res.delete(); e_err = 2'b00;
    ready_ok = cfg_status_at >= 1 && cfg_status_at <= PL;
    npoll = ready_ok ? cfg_status_at : PL;
    for (int ch = 0; ch < 8; ch++) begin
      if (!mask[ch]) continue;
      if (push_step(ch, 0, 1, A_AMUX, 32'(ch))) begin e_err = 2'b01; return; end
      if (push_step(ch, 1, 1, A_TRIG, 32'd1)) begin e_err = 2'b01; return; end
      for (int p = 0; p < npoll; p++)
        if (push_step(ch, 2, 0, A_STATUS, 32'd0)) begin e_err = 2'b01; return; end
      if (!ready_ok) begin e_err = 2'b10; return; end
      if (push_step(ch, 3, 0, A_MEAS, 32'd0)) begin e_err = 2'b01; return; end
      if (push_step(ch, 4, 1, A_TRIG, 32'd0)) begin e_err = 2'b01; return; end
      rr.ch = 3'(ch); rr.data = meas[ch];
      exp_res.push_back(rr);
    end
  endtask

  // Per-cycle monitor state
  int          cyc = 0;
  int          cs = 0;
  int          cur_bp = 0;
  int          vld_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          last_hs = -1;
  int          first_valid = -1;
  int          psel_cycles = 0;
  logic        prev_valid = 0;
  logic        prev_ready = 0;
  logic [2:0]  prev_ch = 0;
  logic [31:0] prev_data = 0;
  logic [1:0]  last_err = 0;

  task automatic step();
    res_t rr;
    @(posedge PCLK);
    #1;
    cyc++;
    if (prev_valid && prev_ready) begin
      rr.ch = prev_ch; rr.data = prev_data;
      got_q.push_back(rr);
      last_hs = cyc - 1;
    end else if (prev_valid) begin
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_ch", 32'(result_ch), 32'(prev_ch));
      check("hold_data", result_data, prev_data);
    end
    if (result_valid) begin
      check("out_no_apb", 32'(PSEL), 32'd0);
      if (first_valid < 0) first_valid = cyc;
    end
    if (PSEL === 1'b1) psel_cycles++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", 32'(busy), 32'd0);
    end
    if (result_valid === 1'b1) begin
      result_ready = (vld_cnt >= cur_bp);
      vld_cnt++;
    end else begin
      result_ready = 0;
      vld_cnt = 0;
    end
    prev_valid = result_valid; prev_ready = result_ready;
    prev_ch = result_ch; prev_data = result_data;
  endtask

  task automatic run_scan(input logic [7:0] mask, input int bp, input bit restart, input bit chk_lat);
    logic [1:0] e_err;
    int n;
    obs_q.delete(); got_q.delete();
    build_expect(mask, e_err);
    cur_bp = bp; done_cnt = 0; done_cyc = -1; last_hs = -1; first_valid = -1; psel_cycles = 0;
    check("err_sticky", 32'(err_code), 32'(last_err));
    ch_mask = mask; start = 1; cs = cyc;
    step();
    start = 0; ch_mask = 8'($urandom);
    check("start_busy", 32'(busy), 32'd1);
    check("start_err_clr", 32'(err_code), 32'd0);
    while (done_cnt == 0 && cyc < cs + 600) begin
      start = restart && (cyc == cs + 3);
      ch_mask = start ? 8'hFF : 8'h00;
      step();
      start = 0;
    end
    check("done_seen", 32'(done_cnt), 32'd1);
    repeat (3) step();
    check("single_done", 32'(done_cnt), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_psel", 32'(PSEL), 32'd0);
    check("err_code", 32'(err_code), 32'(e_err));
    last_err = err_code;
    check("xfer_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("xfer%0d_ctl", i), {19'h0, obs_q[i].wr, obs_q[i].addr}, {19'h0, exp_q[i].wr, exp_q[i].addr});
      check($sformatf("xfer%0d_wdata", i), obs_q[i].data, exp_q[i].data);
    end
    check("res_count", got_q.size(), exp_res.size());
    n = (got_q.size() < exp_res.size()) ? got_q.size() : exp_res.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("res%0d_ch", i), 32'(got_q[i].ch), 32'(exp_res[i].ch));
      check($sformatf("res%0d_data", i), got_q[i].data, exp_res[i].data);
    end
    if (e_err == 2'b00) begin
      if (exp_res.size() > 0) check("done_after_hs", 32'(done_cyc - last_hs), 32'd2);
      else check("done_after_start", 32'(done_cyc - cs), 32'd2);
    end
    if (mask == 8'h00) check("no_psel", 32'(psel_cycles), 32'd0);
    if (chk_lat) check("first_valid_lat", 32'(first_valid - cs), 32'd12);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_psel"}, 32'(PSEL), 32'd0);
    check({pfx, "_penable"}, 32'(PENABLE), 32'd0);
    check({pfx, "_pwrite"}, 32'(PWRITE), 32'd0);
    check({pfx, "_paddr"}, 32'(PADDR), 32'd0);
    check({pfx, "_pwdata"}, PWDATA, 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_err"}, 32'(err_code), 32'd0);
    check({pfx, "_rvalid"}, 32'(result_valid), 32'd0);
    check({pfx, "_rch"}, 32'(result_ch), 32'd0);
    check({pfx, "_rdata"}, result_data, 32'd0);
  endtask

  initial begin
    int found;
    for (int i = 0; i < 8; i++) meas[i] = $urandom;

    // Reset state
    PRESETn = 0;
    repeat (3) step();
    check_zero_outputs("reset");
    PRESETn = 1;
    step();

    // Single channel, zero waits, exact sequence and latency
    meas[2] = 32'h0000_0ABC;
    cfg_waits = 0; cfg_rand_waits = 0; cfg_status_at = 1; cfg_err_en = 0;
    run_scan(8'h04, 2, 0, 1);

    // Two channels with 5-cycle consumer stalls and an ignored start while busy
    run_scan(8'h81, 5, 1, 0);

    // Three wait states per access, status ready on the 4th read (the limit)
    cfg_waits = 3; cfg_status_at = 4;
    run_scan(8'h10, 1, 0, 0);

    // Poll timeout
    cfg_waits = 0; cfg_status_at = 0;
    run_scan(8'h20, 0, 0, 0);

    // PSLVERR on the trigger write of channel 1
    cfg_status_at = 1; cfg_err_en = 1; cfg_err_ch = 1; cfg_err_step = 1;
    run_scan(8'h03, 1, 0, 0);

    // Following start clears the sticky error
    cfg_err_en = 0;
    run_scan(8'h08, 0, 0, 1);

    // Empty mask
    run_scan(8'h00, 0, 0, 0);

    // Reset during the ACCESS phase of a status poll
    cfg_waits = 3; cfg_status_at = 0;
    ch_mask = 8'h01; start = 1;
    step();
    start = 0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (PSEL && PENABLE && !PWRITE && PADDR == A_STATUS) found = 1;
      else step();
    end
    check("poll_access_reached", 32'(found), 32'd1);
    PRESETn = 0;
    step();
    check_zero_outputs("midreset");
    PRESETn = 1;
    step();
    last_err = 2'b00;

    // Randomized scans
    for (int k = 0; k < 8; k++) begin
      logic [7:0] m;
      m = 8'($urandom);
      for (int i = 0; i < 8; i++) meas[i] = $urandom;
      cfg_rand_waits = 1;
      cfg_status_at = int'($urandom_range(0, 5));
      cfg_err_en = ($urandom_range(0, 3) == 0);
      cfg_err_ch = int'($urandom_range(0, 7));
      cfg_err_step = int'($urandom_range(0, 4));
      run_scan(m, int'($urandom_range(0, 3)), m != 8'h00, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
